// File: rtl/link_power_sequencer_pkg.sv
// Shared types and constants for the link power sequencer: FSM state
// encoding (also the StateOut debug encoding), TIA-568B pair indices and
// a small helper used to size the shared timer.
package link_power_pkg;

   // FSM states; the numeric value is what appears on StateOut.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RAMP    = 3'd1,
      SETTLE  = 3'd2,
      CHECK   = 3'd3,
      LINK_UP = 3'd4,
      BACKOFF = 3'd5,
      LOCKOUT = 3'd6
   } state_t;

   // TIA-568B pair to PairActive/PairGood bit index.
   localparam int PAIR_12 = 0;
   localparam int PAIR_36 = 1;
   localparam int PAIR_54 = 2;
   localparam int PAIR_78 = 3;

   // Larger of two integers, for elaboration-time sizing.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/link_power_sequencer_if.sv
// Handshake bundle between the link power sequencer and its environment:
// the enable request, raw pair activity, and all status/enable outputs.
interface link_power_sequencer_if #(
   parameter int NUM_PAIRS = 4
);
   logic                 Enable;
   logic [NUM_PAIRS-1:0] PairActive;
   logic                 SupplyEnable;
   logic                 LnaEnable;
   logic [NUM_PAIRS-1:0] PairGood;
   logic                 LinkUp;
   logic                 Fault;
   logic                 Lockout;
   logic [3:0]           RetryCount;
   logic [2:0]           StateOut;

   // Controller / environment side.
   modport master (
      output Enable, PairActive,
      input  SupplyEnable, LnaEnable, PairGood, LinkUp, Fault, Lockout,
             RetryCount, StateOut
   );

   // Sequencer side.
   modport slave (
      input  Enable, PairActive,
      output SupplyEnable, LnaEnable, PairGood, LinkUp, Fault, Lockout,
             RetryCount, StateOut
   );
endinterface

// File: rtl/link_power_sequencer_monitor.sv
// Per-pair activity monitor: synchronises the raw PairActive line, detects
// toggles, counts them during the qualification window and tracks the
// toggle-free run while the link is up.
module pair_activity_monitor #(
   parameter int MIN_EDGES   = 8,
   parameter int LOSS_CYCLES = 2048
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pair_active,
   input  logic check_en,
   input  logic link_en,
   output logic qualified,
   output logic lost
);
   localparam int IW = $clog2(LOSS_CYCLES + 1);

   // [0],[1] are the synchroniser stages, [2] holds the previous sample.
   logic [2:0]    sync;
   logic          toggle;
   logic [7:0]    edge_cnt;
   logic [IW-1:0] idle_cnt;

   // Two-flop synchroniser plus one history flop for edge detection.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= '0;
      else        sync <= {sync[1:0], pair_active};
   end

   assign toggle = sync[2] ^ sync[1];

   // Saturating toggle counter, held at zero outside the CHECK window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              edge_cnt <= '0;
      else if (!check_en)                      edge_cnt <= '0;
      else if (toggle && edge_cnt != 8'hFF)    edge_cnt <= edge_cnt + 8'd1;
   end

   // Toggle-free run length while the link is up; a toggle always restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              idle_cnt <= '0;
      else if (!link_en || toggle)             idle_cnt <= '0;
      else if (idle_cnt != IW'(LOSS_CYCLES))   idle_cnt <= idle_cnt + IW'(1);
   end

   assign qualified = (edge_cnt >= 8'(MIN_EDGES));
   // Flags the cycle whose closing edge completes LOSS_CYCLES quiet cycles,
   // so the FSM leaves LINK_UP on exactly that edge.
   assign lost = link_en && !toggle && (idle_cnt == IW'(LOSS_CYCLES - 1));

endmodule

// File: rtl/link_power_sequencer.sv
// Link power sequencer: ramps the split supply, then the LNA, qualifies
// activity on every pair, supervises the running link and retries with
// back-off until the retry budget is spent.
module link_power_sequencer
   import link_power_pkg::*;
#(
   parameter int NUM_PAIRS      = 4,
   parameter int RAMP_CYCLES    = 1000,
   parameter int SETTLE_CYCLES  = 500,
   parameter int CHECK_CYCLES   = 256,
   parameter int MIN_EDGES      = 8,
   parameter int LOSS_CYCLES    = 2048,
   parameter int BACKOFF_CYCLES = 4096,
   parameter int MAX_RETRY      = 3
) (
   input  logic                  Clock100Mhz,
   input  logic                  ResetN,
   link_power_sequencer_if.slave bus
);
   localparam int TIMER_MAX = max_int(max_int(max_int(RAMP_CYCLES, SETTLE_CYCLES),
                                              max_int(CHECK_CYCLES, BACKOFF_CYCLES)),
                                      LOSS_CYCLES);
   localparam int TW = $clog2(TIMER_MAX + 1);

   logic [1:0]           rst_sync;
   logic                 rst_n;
   state_t               state, next_state;
   logic [TW-1:0]        timer, timer_load;
   logic [3:0]           retry_count;
   logic [NUM_PAIRS-1:0] qualified, lost;
   logic                 timer_done;

   // Reset asserts asynchronously everywhere but releases on a clock edge.
   always_ff @(posedge Clock100Mhz or negedge ResetN) begin
      if (!ResetN) rst_sync <= '0;
      else         rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_n = rst_sync[1];

   // One activity monitor per pair.
   for (genvar i = 0; i < NUM_PAIRS; i++) begin : g_pair
      pair_activity_monitor #(
         .MIN_EDGES   (MIN_EDGES),
         .LOSS_CYCLES (LOSS_CYCLES)
      ) u_mon (
         .clk         (Clock100Mhz),
         .rst_n       (rst_n),
         .pair_active (bus.PairActive[i]),
         .check_en    (state == CHECK),
         .link_en     (state == LINK_UP),
         .qualified   (qualified[i]),
         .lost        (lost[i])
      );
   end

   assign timer_done = (timer == '0);

   // Next-state decision; a low Enable overrides every other event.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (bus.Enable) next_state = RAMP;
         RAMP:    if (timer_done) next_state = SETTLE;
         SETTLE:  if (timer_done) next_state = CHECK;
         CHECK:   if (timer_done) next_state = (&qualified) ? LINK_UP : BACKOFF;
         LINK_UP: if (|lost)      next_state = BACKOFF;
         BACKOFF: if (timer_done) next_state = (retry_count < 4'(MAX_RETRY)) ? RAMP : LOCKOUT;
         LOCKOUT: next_state = LOCKOUT;
         default: next_state = IDLE;
      endcase
      if (!bus.Enable) next_state = IDLE;
   end

   // Timer value loaded on entry to a state; it counts down to zero, so a
   // state with load N-1 lasts exactly N cycles.
   always_comb begin
      timer_load = '0;
      unique case (next_state)
         RAMP:    timer_load = TW'(RAMP_CYCLES - 1);
         SETTLE:  timer_load = TW'(SETTLE_CYCLES - 1);
         CHECK:   timer_load = TW'(CHECK_CYCLES - 1);
         BACKOFF: timer_load = TW'(BACKOFF_CYCLES - 1);
         default: timer_load = '0;
      endcase
   end

   // State register, shared timer and retry bookkeeping.
   always_ff @(posedge Clock100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         timer       <= '0;
         retry_count <= '0;
      end else begin
         state <= next_state;
         if (next_state != state) timer <= timer_load;
         else if (!timer_done)    timer <= timer - TW'(1);
         if (next_state == IDLE)
            retry_count <= '0;
         else if (next_state == BACKOFF && state != BACKOFF)
            retry_count <= retry_count + 4'd1;
      end
   end

   // Outputs decode straight from the state register, so reset clears them
   // asynchronously and both enables drop on the same edge.
   assign bus.SupplyEnable = state inside {RAMP, SETTLE, CHECK, LINK_UP};
   assign bus.LnaEnable    = state inside {SETTLE, CHECK, LINK_UP};
   assign bus.PairGood     = {NUM_PAIRS{state == LINK_UP}};
   assign bus.LinkUp       = (state == LINK_UP);
   assign bus.Fault        = state inside {BACKOFF, LOCKOUT};
   assign bus.Lockout      = (state == LOCKOUT);
   assign bus.RetryCount   = retry_count;
   assign bus.StateOut     = state;

endmodule
